// File: rtl/fft_ctrl_out.sv
// Output-side FFT controller: captures one Avalon-ST frame per arm edge into a
// dual-port spectrum buffer and reports completion, bin count and framing errors.
module fft_ctrl_out #(
    parameter int BUSWIDTH  = 12,
    parameter int DATAWIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ARM,
    input  logic [BUSWIDTH-1:0]    FRAMELENGTH,
    input  logic                   sink_valid,
    input  logic                   sink_sop,
    input  logic                   sink_eop,
    input  logic [DATAWIDTH-1:0]   sink_real,
    input  logic [DATAWIDTH-1:0]   sink_imag,
    input  logic [1:0]             sink_error,
    output logic                   sink_ready,
    input  logic [BUSWIDTH-1:0]    rd_addr,
    output logic [2*DATAWIDTH-1:0] rd_data,
    output logic [BUSWIDTH:0]      BINCNT,
    output logic                   DONE,
    output logic [2:0]             ERR
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_WAIT = 4'b0010,
        S_CAP  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam logic [BUSWIDTH:0] ONE_CNT  = {{BUSWIDTH{1'b0}}, 1'b1};
    localparam logic [BUSWIDTH:0] FULL_CNT = {1'b1, {BUSWIDTH{1'b0}}};

    state_t                   state_q;
    logic                     ready_q;
    logic                     done_q;
    logic [2:0]               err_q;
    logic [BUSWIDTH:0]        bincnt_q;
    logic [BUSWIDTH:0]        bincnt_d;
    logic [BUSWIDTH:0]        len_q;
    logic                     arm_q;
    logic                     arm_prev_q;
    logic [2*DATAWIDTH-1:0]   rd_data_q;
    logic [2*DATAWIDTH-1:0]   mem_q [2**BUSWIDTH];

    logic                     accept;
    logic                     arm_edge;
    logic                     wr_en;
    logic [BUSWIDTH-1:0]      wr_addr;

    assign accept   = sink_valid && ready_q;
    assign arm_edge = arm_q && !arm_prev_q;
    assign bincnt_d = bincnt_q + ONE_CNT;
    // A sop beat always restarts the frame at bin 0; non-sop beats only land while capturing.
    assign wr_en    = accept && (sink_sop || (state_q == S_CAP));
    assign wr_addr  = sink_sop ? '0 : bincnt_q[BUSWIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 3'b000;
            bincnt_q   <= '0;
            len_q      <= '0;
            arm_q      <= 1'b0;
            arm_prev_q <= 1'b0;
        end else begin
            arm_q      <= ARM;
            arm_prev_q <= arm_q;
            if (accept && (sink_error != 2'b00)) err_q[2] <= 1'b1;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_edge) begin
                        len_q    <= (FRAMELENGTH == '0) ? FULL_CNT : {1'b0, FRAMELENGTH};
                        bincnt_q <= '0;
                        err_q    <= 3'b000;
                        done_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (accept && sink_sop) begin
                        bincnt_q <= ONE_CNT;
                        if (len_q == ONE_CNT || sink_eop) begin
                            if (len_q == ONE_CNT ? !sink_eop : 1'b1) err_q[0] <= 1'b1;
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_CAP;
                        end
                    end
                end
                S_CAP: begin
                    if (accept) begin
                        if (sink_sop) begin
                            err_q[1] <= 1'b1;
                            bincnt_q <= ONE_CNT;
                        end else begin
                            bincnt_q <= bincnt_d;
                            if (bincnt_d == len_q || sink_eop) begin
                                if (bincnt_d != len_q || !sink_eop) err_q[0] <= 1'b1;
                                state_q <= S_DONE;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Buffer is never cleared; read-before-write gives old data on address collisions.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_addr] <= {sink_imag, sink_real};
    end

    always_ff @(posedge CLK) begin
        if (RST) rd_data_q <= '0;
        else     rd_data_q <= mem_q[rd_addr];
    end

    assign sink_ready = ready_q;
    assign rd_data    = rd_data_q;
    assign BINCNT     = bincnt_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_fft_ctrl_out.sv
// Directed bench for fft_ctrl_out: per-cycle comparison against a frame-level
// behavioural model plus hand-computed literal expectations.
module tb_fft_ctrl_out;
    localparam int BW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;

    logic          CLK = 1'b0;
    logic          RST, ARM;
    logic [BW-1:0] FRAMELENGTH;
    logic          sink_valid, sink_sop, sink_eop;
    logic [DW-1:0] sink_real, sink_imag;
    logic [1:0]    sink_error;
    logic          sink_ready;
    logic [BW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [BW:0]   BINCNT;
    logic          DONE;
    logic [2:0]    ERR;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    fft_ctrl_out #(.BUSWIDTH(BW), .DATAWIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .ARM(ARM), .FRAMELENGTH(FRAMELENGTH),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag), .sink_error(sink_error),
        .sink_ready(sink_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .BINCNT(BINCNT), .DONE(DONE), .ERR(ERR)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 hunting for sop, 2 inside frame, 3 frame complete
    bit          m_init = 0;
    int          m_phase, m_len, m_cnt;
    bit          m_ready, m_done, m_a1, m_a2;
    bit [2:0]    m_err;
    logic [31:0] shadow [DEPTH];
    bit          known  [DEPTH];
    logic [31:0] m_rd;
    bit          m_rd_known;

    always @(posedge CLK) begin
        if (RST) begin
            m_init = 1; m_phase = 0; m_len = 0; m_cnt = 0;
            m_ready = 0; m_done = 0; m_err = 0; m_a1 = 0; m_a2 = 0;
            m_rd = 0; m_rd_known = 1;
        end else begin
            m_rd = shadow[rd_addr];
            m_rd_known = known[rd_addr];
            if (sink_valid && m_ready) begin
                if (sink_error != 0) m_err[2] = 1;
                if (sink_sop) begin
                    if (m_phase == 2) m_err[1] = 1;
                    shadow[0] = {sink_imag, sink_real};
                    known[0] = 1;
                    m_cnt = 1;
                    if (m_phase == 1) begin
                        if (m_len == 1) begin
                            m_phase = 3;
                            if (!sink_eop) m_err[0] = 1;
                        end else if (sink_eop) begin
                            m_phase = 3;
                            m_err[0] = 1;
                        end else m_phase = 2;
                    end
                end else if (m_phase == 2) begin
                    shadow[m_cnt] = {sink_imag, sink_real};
                    known[m_cnt] = 1;
                    m_cnt++;
                    if (m_cnt == m_len) begin
                        m_phase = 3;
                        if (!sink_eop) m_err[0] = 1;
                    end else if (sink_eop) begin
                        m_phase = 3;
                        m_err[0] = 1;
                    end
                end
            end else if (m_a1 && !m_a2 && (m_phase == 0 || m_phase == 3)) begin
                m_len = (FRAMELENGTH == 0) ? DEPTH : int'(FRAMELENGTH);
                m_cnt = 0; m_err = 0; m_phase = 1;
            end
            m_a2 = m_a1;
            m_a1 = ARM;
            m_ready = (m_phase == 1 || m_phase == 2);
            m_done  = (m_phase == 3);
        end
    end

    always @(negedge CLK) begin
        if (m_init) begin
            chk("model_ready", sink_ready, m_ready);
            chk("model_done", DONE, m_done);
            chk("model_err", ERR, m_err);
            chk("model_bincnt", BINCNT, m_cnt);
            if (m_rd_known) chk("model_rd_data", rd_data, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic arm(input logic [BW-1:0] len);
        int n = 0;
        FRAMELENGTH = len;
        ARM = 1;
        @(negedge CLK);
        ARM = 0;
        while (!sink_ready && n < 10) begin @(negedge CLK); n++; end
        if (!sink_ready) begin
            checks++; failures++;
            $display("FAIL arm_timeout: sink_ready got 0 expected 1");
        end
    endtask

    task automatic beat(input bit sop, input bit eop, input logic [DW-1:0] re,
                        input logic [DW-1:0] im, input logic [1:0] er);
        int n = 0;
        sink_valid = 1; sink_sop = sop; sink_eop = eop;
        sink_real = re; sink_imag = im; sink_error = er;
        while (!sink_ready && n < 50) begin @(negedge CLK); n++; end
        if (!sink_ready) begin
            checks++; failures++;
            $display("FAIL beat_timeout: sink_ready got 0 expected 1");
        end
        @(negedge CLK);
        sink_valid = 0; sink_sop = 0; sink_eop = 0; sink_error = 0;
    endtask

    task automatic read_chk(input string nm, input logic [BW-1:0] a, input logic [31:0] exp);
        rd_addr = a;
        @(negedge CLK);
        chk(nm, rd_data, exp);
    endtask

    task automatic reset_chk(input string nm);
        chk({nm, "_ready"}, sink_ready, 0);
        chk({nm, "_done"}, DONE, 0);
        chk({nm, "_err"}, ERR, 0);
        chk({nm, "_bincnt"}, BINCNT, 0);
        chk({nm, "_rd"}, rd_data, 0);
    endtask

    initial begin
        RST = 1; ARM = 0; FRAMELENGTH = 0; sink_valid = 0; sink_sop = 0; sink_eop = 0;
        sink_real = 0; sink_imag = 0; sink_error = 0; rd_addr = 0;
        repeat (3) @(negedge CLK);
        reset_chk("por");
        RST = 0;
        @(negedge CLK);

        // nominal frame of 8
        arm(12'd8);
        for (int i = 0; i < 8; i++) beat(i == 0, i == 7, 16'(i), 16'(-i), 2'b00);
        chk("nom_done", DONE, 1);
        chk("nom_err", ERR, 0);
        chk("nom_bincnt", BINCNT, 8);
        chk("nom_ready", sink_ready, 0);
        read_chk("nom_rd5", 12'd5, 32'hFFFB_0005);
        read_chk("nom_rd7", 12'd7, 32'hFFF9_0007);

        // leading garbage, gaps, then a frame of 4
        arm(12'd4);
        for (int i = 0; i < 3; i++) beat(0, 0, 16'hAAAA, 16'hBBBB, 2'b00);
        for (int i = 0; i < 4; i++) begin
            beat(i == 0, i == 3, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 2'b00);
            if (i < 3) repeat (2) @(negedge CLK);
        end
        chk("bp_done", DONE, 1);
        chk("bp_err", ERR, 0);
        chk("bp_bincnt", BINCNT, 4);
        sink_valid = 1; sink_sop = 1; sink_real = 16'hDEAD; sink_imag = 16'hBEEF;
        repeat (3) begin
            @(negedge CLK);
            chk("bp_ready_after_done", sink_ready, 0);
        end
        sink_valid = 0; sink_sop = 0;
        chk("bp_no_5th", BINCNT, 4);
        for (int i = 0; i < 4; i++)
            read_chk("bp_rd", 12'(i), {16'h0200 + 16'(i), 16'h0100 + 16'(i)});

        // early eop on beat 5 of 8
        arm(12'd8);
        for (int i = 0; i < 6; i++) beat(i == 0, i == 5, 16'(i), 16'(i), 2'b00);
        chk("early_done", DONE, 1);
        chk("early_err", ERR, 3'b001);
        chk("early_bincnt", BINCNT, 6);

        // mid-frame sop and missing eop, length 4
        arm(12'd4);
        beat(1, 0, 16'h10, 0, 2'b00);
        beat(0, 0, 16'h11, 0, 2'b00);
        beat(1, 0, 16'h20, 0, 2'b00);
        beat(0, 0, 16'h21, 0, 2'b00);
        beat(0, 0, 16'h22, 0, 2'b00);
        chk("midsop_not_yet", DONE, 0);
        beat(0, 0, 16'h23, 0, 2'b00);
        chk("midsop_done", DONE, 1);
        chk("midsop_err", ERR, 3'b011);
        chk("midsop_bincnt", BINCNT, 4);
        read_chk("midsop_rd0", 12'd0, 32'h0000_0020);

        // core error then re-arm with a clean frame
        arm(12'd8);
        for (int i = 0; i < 8; i++) beat(i == 0, i == 7, 16'(i), 16'(-i), (i == 2) ? 2'b01 : 2'b00);
        chk("cerr_err", ERR, 3'b100);
        chk("cerr_done", DONE, 1);
        arm(12'd8);
        chk("rearm_done", DONE, 0);
        chk("rearm_err", ERR, 0);
        for (int i = 0; i < 8; i++) beat(i == 0, i == 7, 16'(i), 16'(-i), 2'b00);
        chk("clean_err", ERR, 0);
        chk("clean_done", DONE, 1);

        // reset mid-frame
        arm(12'd8);
        for (int i = 0; i < 3; i++) beat(i == 0, 0, 16'(i), 16'(i), 2'b00);
        chk("pre_rst_bincnt", BINCNT, 3);
        RST = 1;
        @(negedge CLK);
        reset_chk("midrst");
        RST = 0;
        @(negedge CLK);

        // FRAMELENGTH=0 means a full 4096-bin frame
        arm(12'd0);
        for (int i = 0; i < DEPTH; i++) beat(i == 0, i == DEPTH - 1, 16'(i), 16'(i * 3), 2'b00);
        chk("full_done", DONE, 1);
        chk("full_bincnt", BINCNT, 13'd4096);
        chk("full_err", ERR, 0);
        read_chk("full_rd4095", 12'd4095, 32'h2FFD_0FFF);
        read_chk("full_rd1", 12'd1, 32'h0003_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_ctrl_out.md
# fft_ctrl_out

Output-side controller for the FFT path. It accepts one Avalon-ST frame from the FFT core source (real/imag bins with sop/eop/valid) and applies ready backpressure. It writes the bins by index into an internal dual-port buffer and reports frame completion and framing errors. Downstream readout logic reads the buffered spectrum through a registered random-access read port.

## Interface
- BUSWIDTH, 12, bin address width; buffer depth 2^BUSWIDTH
- DATAWIDTH, 16, width of each real/imag component

- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- ARM  in  1  level; its rising edge arms capture of one frame
- FRAMELENGTH  in  BUSWIDTH  expected bins per frame, sampled on the arm edge; 0 means 2^BUSWIDTH
- sink_valid  in  1  FFT source beat valid
- sink_sop  in  1  start of packet, qualified by sink_valid
- sink_eop  in  1  end of packet, qualified by sink_valid
- sink_real  in  DATAWIDTH  real component
- sink_imag  in  DATAWIDTH  imaginary component
- sink_error  in  2  FFT core error code; nonzero means error
- sink_ready  out  1  registered backpressure to the FFT core
- rd_addr  in  BUSWIDTH  buffer read address
- rd_data  out  2*DATAWIDTH  {imag, real} at rd_addr, registered
- BINCNT  out  BUSWIDTH+1  bins written in the current or last frame
- DONE  out  1  frame captured; sticky until the next arm
- ERR  out  3  sticky flags: [0] length/eop mismatch, [1] sop mid-frame, [2] core error

## Operation
- Beat acceptance: a beat is accepted in any cycle where sink_valid and sink_ready are both 1 (readyLatency 0).
- ARM is registered once. The arm edge is registered ARM high while its previous registered value was low.
- States: IDLE, WAIT_SOP, CAPTURE, DONE (one-hot).
- IDLE
  - sink_ready = 0.
  - On the arm edge: latch FRAMELENGTH into an internal BUSWIDTH+1-bit length L (0 becomes 2^BUSWIDTH). Clear BINCNT, DONE and ERR. Go to WAIT_SOP.
- WAIT_SOP
  - sink_ready = 1.
  - Accepted beats without sop are discarded and do not change ERR.
  - An accepted sop beat is written to address 0 and sets BINCNT = 1.
    - If L == 1: go to DONE. Additionally set ERR[0] if eop was not present on that beat.
    - Otherwise: go to CAPTURE. If eop was present on that beat, set ERR[0] and go to DONE instead.
- CAPTURE
  - sink_ready = 1.
  - Each accepted beat is written at address BINCNT[BUSWIDTH-1:0], then BINCNT increments.
  - Accepted sop beat: set ERR[1], write it at address 0, set BINCNT = 1 (restart the frame). This takes priority over the length checks.
  - Accepted beat that makes BINCNT == L:
    - go to DONE;
    - set ERR[0] if eop is absent on that beat.
  - Accepted eop beat that leaves BINCNT < L: set ERR[0] and go to DONE.
- Any accepted beat with sink_error != 0, in WAIT_SOP or CAPTURE, sets ERR[2].
- DONE
  - DONE = 1, sink_ready = 0.
  - The arm edge behaves exactly as it does in IDLE.
- Arm edges in WAIT_SOP or CAPTURE are ignored.
- Buffer: 2^BUSWIDTH x 2*DATAWIDTH simple dual-port RAM with one write port and one read port.
  - Buffer contents are not cleared by reset or by arming.
  - Same-address read and write in the same cycle returns the old data.
- BINCNT saturates at L and never wraps.

## Timing
- Reset values:
  - State = IDLE.
  - sink_ready = 0, DONE = 0, ERR = 0, BINCNT = 0, rd_data = 0.
  - The registered ARM history is 0. An ARM input held high through the release of reset therefore produces an arm edge.
- Arm latency:
  - ARM rises at cycle n.
  - The arm edge is seen at n+1.
  - State changes and sink_ready = 1 at n+2.
- Frame end: DONE = 1 and sink_ready = 0 in the cycle after the final beat is accepted. No further beat is accepted.
- rd_data is valid one cycle after rd_addr is presented.
- ERR bits update in the cycle after the offending beat is accepted.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and sink_ready drops at that edge.

## Test plan
- Nominal capture:
  - FRAMELENGTH=8, pulse ARM. Send 8 beats (sop on beat 0, eop on beat 7), real=i, imag=-i.
  - Required: DONE=1 one cycle after beat 7, ERR=0, BINCNT=8.
  - Required: rd_addr=5 returns {-5,5} one cycle later.
- Leading garbage plus backpressure:
  - Send 3 valid beats without sop, then a sop frame of 4 (FRAMELENGTH=4).
  - Required: the garbage beats are dropped, addresses 0–3 hold the frame, ERR=0.
  - Required: sink_ready=0 after DONE, and a 5th beat is not accepted.
- Early eop:
  - FRAMELENGTH=8, eop on beat 5.
  - Required: DONE=1, ERR=3'b001, BINCNT=6.
- Missing eop and mid-frame sop:
  - FRAMELENGTH=4. Beats: sop, d, sop, d, d, d with no eop.
  - Required: ERR=3'b011, DONE after the 4th beat following the second sop, BINCNT=4.
- Core error and re-arm:
  - Nominal frame with sink_error=2'b01 on beat 2.
  - Required: ERR=3'b100.
  - Re-arm, then a clean frame. Required: ERR=0 and DONE clears at re-arm.
- Reset mid-frame and FRAMELENGTH=0:
  - Assert RST after 3 beats. Required: all outputs return to reset values next cycle.
  - Arm with FRAMELENGTH=0 and send 4096 beats (BUSWIDTH=12). Required: DONE=1, BINCNT=4096, ERR=0.
